// File: rtl/lc3b_mem_ctrl_pkg.sv
// lc3b_mem_ctrl_pkg
// Shared encodings for the LC-3b memory path: DATA_SIZE and R_W values
// (also used by the MDR store logic), the memory FSM state encoding, the
// request record latched at acceptance and the write byte-enable decode.
package lc3b_mem_ctrl_pkg;

  localparam logic DATA_BYTE = 1'b0;
  localparam logic DATA_WORD = 1'b1;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    MEM_IDLE   = 2'd0,
    MEM_ACCESS = 2'd1,
    MEM_DONE   = 2'd2
  } mem_state_t;

  // Everything about an access that must stay stable after acceptance.
  // The word index is kept separately because its width is a parameter.
  typedef struct packed {
    logic        r_w;
    logic        data_size;
    logic        lsb;         // MAR[0]
    logic        misaligned;  // word access on an odd byte address
    logic [15:0] mdr;
  } mem_req_t;

  // Byte-lane write enables {WE1, WE0}. The MDR already holds the byte in
  // the lane selected by MAR[0], so only the enables depend on the address.
  function automatic logic [1:0] byte_enables(input logic data_size,
                                              input logic lsb);
    logic [1:0] we;
    if (data_size == DATA_WORD) begin
      we = 2'b11;
    end else if (lsb) begin
      we = 2'b10;
    end else begin
      we = 2'b01;
    end
    return we;
  endfunction

endpackage

// File: rtl/lc3b_mem_ctrl_if.sv
// lc3b_mem_ctrl_if
// Request/response bundle between the microsequencer/MDR side (master)
// and the memory controller (slave).
//   MIO_EN, R_W, DATA_SIZE, MAR, MDR : request, driven by master
//   inmux_data, R, ALIGN_ERR, busy   : response, driven by slave
interface lc3b_mem_ctrl_if #(
  parameter int ADDR_W = 16
);

  logic              MIO_EN;
  logic              R_W;
  logic              DATA_SIZE;
  logic [ADDR_W-1:0] MAR;
  logic [15:0]       MDR;
  logic [15:0]       inmux_data;
  logic              R;
  logic              ALIGN_ERR;
  logic              busy;

  modport master (
    output MIO_EN, R_W, DATA_SIZE, MAR, MDR,
    input  inmux_data, R, ALIGN_ERR, busy
  );

  modport slave (
    input  MIO_EN, R_W, DATA_SIZE, MAR, MDR,
    output inmux_data, R, ALIGN_ERR, busy
  );

endinterface

// File: rtl/lc3b_mem_array.sv
// lc3b_mem_array
// MEM_WORDS x 16 RAM built from two independent byte lanes so that byte
// stores need no read-modify-write. Synchronous write, asynchronous read.
// Contents are not affected by any reset.
//   clk    : write clock
//   we     : {WE1, WE0} byte-lane write enables
//   index  : word index
//   wdata  : write word (lane 1 = [15:8], lane 0 = [7:0])
//   rdata  : word at index, combinational
module lc3b_mem_array #(
  parameter int MEM_AW = 15
) (
  input  logic              clk,
  input  logic [1:0]        we,
  input  logic [MEM_AW-1:0] index,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata
);

  localparam int MEM_WORDS = 2 ** MEM_AW;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic [7:0] lane_mem [MEM_WORDS];

      always_ff @(posedge clk) begin
        if (we[gi]) begin
          lane_mem[index] <= wdata[gi*8 +: 8];
        end
      end

      assign rdata[gi*8 +: 8] = lane_mem[index];
    end
  endgenerate

endmodule

// File: rtl/lc3b_mem_ctrl.sv
// lc3b_mem_ctrl
// Memory-side partner of the MDR stage. Each MIO_EN request runs one
// multi-cycle access: the request is latched in IDLE (cycle 0), waits in
// ACCESS, and completes in DONE (cycle WAIT_CYCLES) with a one-cycle R
// pulse. Reads return the aligned word on inmux_data, registered so it is
// valid while R=1; writes commit on the edge that ends DONE.
//   clk, reset : clock, synchronous active-high reset
//   bus        : lc3b_mem_ctrl_if slave (request in, inmux_data/R/
//                ALIGN_ERR/busy out)
module lc3b_mem_ctrl
  import lc3b_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int MEM_AW      = 15,
  parameter int WAIT_CYCLES = 4
) (
  input  logic           clk,
  input  logic           reset,
  lc3b_mem_ctrl_if.slave bus
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  mem_state_t        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  mem_req_t          req_reg, req_next;
  logic [MEM_AW-1:0] index_reg, index_next;
  logic [15:0]       inmux_reg;
  logic [1:0]        we;
  logic [15:0]       rdata;
  logic              accept;

  assign accept = (state_reg == MEM_IDLE) && bus.MIO_EN;

  // Request latch next value: inputs are only looked at on acceptance,
  // so changes while an access is in flight have no effect.
  always_comb begin
    req_next   = req_reg;
    index_next = index_reg;
    if (accept) begin
      req_next.r_w        = bus.R_W;
      req_next.data_size  = bus.DATA_SIZE;
      req_next.lsb        = bus.MAR[0];
      req_next.misaligned = (bus.DATA_SIZE == DATA_WORD) && bus.MAR[0];
      req_next.mdr        = bus.MDR;
      index_next          = bus.MAR[MEM_AW:1];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= MEM_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state. The counter holds the cycles remaining until R; the last
  // ACCESS cycle is the one where it reads 1, so it reaches 0 as DONE is
  // entered. With WAIT_CYCLES=1 there is no ACCESS cycle at all.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      MEM_IDLE: begin
        if (bus.MIO_EN) begin
          cnt_next   = CNT_LOAD;
          state_next = (WAIT_CYCLES == 1) ? MEM_DONE : MEM_ACCESS;
        end
      end
      MEM_ACCESS: begin
        if (!bus.MIO_EN) begin
          state_next = MEM_IDLE;  // abandoned request: no write, no R
        end else begin
          cnt_next = cnt_reg - 1'b1;
          if (cnt_reg == CNT_W'(1)) begin
            state_next = MEM_DONE;
          end
        end
      end
      MEM_DONE: begin
        state_next = MEM_IDLE;
      end
      default: begin
        state_next = MEM_IDLE;
      end
    endcase
  end

  // Outputs. The write is gated with reset so a reset landing in DONE
  // also suppresses the commit.
  always_comb begin
    bus.R         = 1'b0;
    bus.ALIGN_ERR = 1'b0;
    bus.busy      = 1'b0;
    we            = 2'b00;
    unique case (state_reg)
      MEM_ACCESS: begin
        bus.busy = 1'b1;
      end
      MEM_DONE: begin
        bus.R         = 1'b1;
        bus.ALIGN_ERR = req_reg.misaligned;
        if ((req_reg.r_w == RW_WRITE) && !req_reg.misaligned && !reset) begin
          we = byte_enables(req_reg.data_size, req_reg.lsb);
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath registers. inmux_data is loaded on the edge entering DONE;
  // the array is addressed with index_next so this also works when DONE
  // follows IDLE directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg   <= '0;
      req_reg   <= '0;
      index_reg <= '0;
      inmux_reg <= 16'h0000;
    end else begin
      cnt_reg   <= cnt_next;
      req_reg   <= req_next;
      index_reg <= index_next;
      if ((state_next == MEM_DONE) && (req_next.r_w == RW_READ) &&
          !req_next.misaligned) begin
        inmux_reg <= rdata;
      end
    end
  end

  assign bus.inmux_data = inmux_reg;

  lc3b_mem_array #(
    .MEM_AW(MEM_AW)
  ) u_array (
    .clk  (clk),
    .we   (we),
    .index(index_next),
    .wdata(req_reg.mdr),
    .rdata(rdata)
  );

endmodule
